// File: rtl/vote_pkg.sv
// Shared types and helpers for the ballot controller and its tally bank.
package vote_pkg;

    localparam int unsigned DEF_NUM_CAND = 4;
    localparam int unsigned DEF_CNT_W    = 8;
    localparam int unsigned IDX_W        = $clog2(DEF_NUM_CAND);
    localparam int unsigned TOT_W        = DEF_CNT_W + IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        COMMIT,
        LOCK,
        RESULT
    } state_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/vote_tally.sv
// Saturating per-candidate tally bank with registered display mux and grand total.
module vote_tally
    import vote_pkg::*;
#(
    parameter int unsigned NUM_CAND = DEF_NUM_CAND,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                inc_en,
    input  logic [$clog2(NUM_CAND)-1:0]         inc_idx,
    input  logic                                show,
    input  logic [$clog2(NUM_CAND)-1:0]         disp_sel,
    output logic                                sat_hit,
    output logic [CNT_W-1:0]                    disp_count,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]   total
);

    localparam int unsigned SEL_W   = $clog2(NUM_CAND);
    localparam int unsigned TOTAL_W = CNT_W + SEL_W;

    logic [CNT_W-1:0]   cnt_q [NUM_CAND];
    logic [CNT_W-1:0]   cnt_d [NUM_CAND];
    logic [CNT_W-1:0]   disp_q, disp_d, sel_cnt;
    logic [TOTAL_W-1:0] total_q, total_d, sum;

    always_comb begin
        cnt_d   = cnt_q;
        sat_hit = 1'b0;
        sum     = '0;
        sel_cnt = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            sum = sum + TOTAL_W'(cnt_q[i]);
            if (inc_en && inc_idx == SEL_W'(i)) begin
                if (cnt_q[i] == '1) begin
                    sat_hit = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
            // Out-of-range selects never match, so they read as zero.
            if (disp_sel == SEL_W'(i)) begin
                sel_cnt = cnt_q[i];
            end
        end
        disp_d  = show ? sel_cnt : '0;
        total_d = show ? sum : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '{default: '0};
            disp_q  <= '0;
            total_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            total_q <= total_d;
        end
    end

    assign disp_count = disp_q;
    assign total      = total_q;

endmodule

// File: rtl/vote_sequencer.sv
// Ballot FSM: arms one ballot, admits a single-candidate press, commits it, then locks out.
module vote_sequencer
    import vote_pkg::*;
#(
    parameter int unsigned NUM_CAND    = DEF_NUM_CAND,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned LOCKOUT     = 8,
    parameter int unsigned ARM_TIMEOUT = 64
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                mode,
    input  logic                                ballot_arm,
    input  logic [NUM_CAND-1:0]                 vote_pulse,
    input  logic [$clog2(NUM_CAND)-1:0]         disp_sel,
    output logic                                armed,
    output logic                                vote_ack,
    output logic                                vote_reject,
    output logic                                busy,
    output logic                                sat_flag,
    output logic [CNT_W-1:0]                    disp_count,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]   total
);

    localparam int unsigned SEL_W = $clog2(NUM_CAND);
    localparam int unsigned TMO_W = $clog2(ARM_TIMEOUT);
    localparam int unsigned LCK_W = $clog2(LOCKOUT + 1);

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [LCK_W-1:0]   lck_q, lck_d;
    logic [SEL_W-1:0]   idx_q, idx_d, hit_idx;
    logic               armed_q, armed_d;
    logic               ack_q, ack_d;
    logic               rej_q, rej_d;
    logic               busy_q, busy_d;
    logic               sat_q, sat_d;
    logic               sat_hit;
    int unsigned        pc;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        lck_d   = lck_q;
        idx_d   = idx_q;
        armed_d = 1'b0;
        ack_d   = 1'b0;
        rej_d   = 1'b0;
        busy_d  = 1'b0;
        sat_d   = sat_q | sat_hit;
        pc      = popcount(32'(vote_pulse));
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (vote_pulse[i]) hit_idx = SEL_W'(i);
        end

        case (state_q)
            IDLE: begin
                if (mode) begin
                    state_d = RESULT;
                end else if (ballot_arm) begin
                    state_d = ARMED;
                    armed_d = 1'b1;
                    tmo_d   = TMO_W'(ARM_TIMEOUT - 1);
                end
            end
            ARMED: begin
                if (mode) begin
                    state_d = RESULT;
                end else if (pc == 1) begin
                    state_d = COMMIT;
                    idx_d   = hit_idx;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                end else if (pc >= 2 || tmo_q == '0) begin
                    state_d = LOCK;
                    rej_d   = 1'b1;
                    busy_d  = 1'b1;
                    lck_d   = LCK_W'(LOCKOUT - 1);
                end else begin
                    tmo_d   = tmo_q - TMO_W'(1);
                    armed_d = 1'b1;
                end
            end
            COMMIT: begin
                state_d = LOCK;
                busy_d  = 1'b1;
                lck_d   = LCK_W'(LOCKOUT - 1);
            end
            LOCK: begin
                if (lck_q == '0) begin
                    state_d = IDLE;
                end else begin
                    lck_d  = lck_q - LCK_W'(1);
                    busy_d = 1'b1;
                end
            end
            RESULT: begin
                if (!mode) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            lck_q   <= '0;
            idx_q   <= '0;
            armed_q <= 1'b0;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
            busy_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            lck_q   <= lck_d;
            idx_q   <= idx_d;
            armed_q <= armed_d;
            ack_q   <= ack_d;
            rej_q   <= rej_d;
            busy_q  <= busy_d;
            sat_q   <= sat_d;
        end
    end

    vote_tally #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W)
    ) u_tally (
        .clock      (clock),
        .reset      (reset),
        .inc_en     (state_q == COMMIT),
        .inc_idx    (idx_q),
        .show       (state_q == RESULT && mode),
        .disp_sel   (disp_sel),
        .sat_hit    (sat_hit),
        .disp_count (disp_count),
        .total      (total)
    );

    assign armed       = armed_q;
    assign vote_ack    = ack_q;
    assign vote_reject = rej_q;
    assign busy        = busy_q;
    assign sat_flag    = sat_q;

endmodule

// File: tb/tb_vote_sequencer.sv
// Directed bench for vote_sequencer with hand-computed expectations.
module tb_vote_sequencer;
    import vote_pkg::*;

    logic             clock;
    logic             reset;
    logic             mode;
    logic             ballot_arm;
    logic [3:0]       vote_pulse;
    logic [IDX_W-1:0] disp_sel;
    logic             armed, vote_ack, vote_reject, busy, sat_flag;
    logic [7:0]       disp_count;
    logic [TOT_W-1:0] total;

    int vectors;
    int miscompares;

    vote_sequencer #(
        .NUM_CAND    (4),
        .CNT_W       (8),
        .LOCKOUT     (8),
        .ARM_TIMEOUT (64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .ballot_arm  (ballot_arm),
        .vote_pulse  (vote_pulse),
        .disp_sel    (disp_sel),
        .armed       (armed),
        .vote_ack    (vote_ack),
        .vote_reject (vote_reject),
        .busy        (busy),
        .sat_flag    (sat_flag),
        .disp_count  (disp_count),
        .total       (total)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Counts busy cycles until the lockout ends, bounded at 40.
    task automatic run_busy(output int n);
        n = 0;
        for (int k = 0; k < 40 && busy; k++) begin
            n++;
            tick();
        end
    endtask

    task automatic do_vote(input logic [3:0] mask);
        int n;
        ballot_arm = 1'b1;
        tick();
        ballot_arm = 1'b0;
        vote_pulse = mask;
        tick();
        vote_pulse = '0;
        run_busy(n);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        mode        = 1'b0;
        ballot_arm  = 1'b0;
        vote_pulse  = '0;
        disp_sel    = '0;

        #3;
        chk("rst_armed", 32'(armed), 0);
        chk("rst_ack", 32'(vote_ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_total", 32'(total), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single vote for candidate 1, pressed two cycles after arming.
        ballot_arm = 1'b1;
        tick();
        ballot_arm = 1'b0;
        chk("t1_armed", 32'(armed), 1);
        tick();
        vote_pulse = 4'b0010;
        tick();
        vote_pulse = '0;
        chk("t1_ack", 32'(vote_ack), 1);
        chk("t1_rej", 32'(vote_reject), 0);
        chk("t1_armed_off", 32'(armed), 0);
        run_busy(n);
        chk("t1_busy_cycles", 32'(n), 9);
        mode     = 1'b1;
        disp_sel = 2'd1;
        tick();
        tick();
        chk("t1_disp", 32'(disp_count), 1);
        chk("t1_total", 32'(total), 1);
        mode = 1'b0;
        tick();
        chk("t1_disp_off", 32'(disp_count), 0);
        chk("t1_total_off", 32'(total), 0);

        // Multi-press reject.
        ballot_arm = 1'b1;
        tick();
        ballot_arm = 1'b0;
        vote_pulse = 4'b0110;
        tick();
        vote_pulse = '0;
        chk("t2_rej", 32'(vote_reject), 1);
        chk("t2_ack", 32'(vote_ack), 0);
        run_busy(n);
        chk("t2_busy_cycles", 32'(n), 8);

        // Timeout, with a press during lockout.
        ballot_arm = 1'b1;
        tick();
        ballot_arm = 1'b0;
        n = 0;
        for (int k = 0; k < 100 && armed; k++) begin
            n++;
            tick();
        end
        chk("t3_armed_cycles", 32'(n), 64);
        chk("t3_rej", 32'(vote_reject), 1);
        vote_pulse = 4'b0001;
        tick();
        vote_pulse = '0;
        chk("t3_rej_pulse", 32'(vote_reject), 0);
        run_busy(n);
        chk("t3_lock_rest", 32'(n), 7);
        mode     = 1'b1;
        disp_sel = 2'd0;
        tick();
        tick();
        chk("t3_disp0", 32'(disp_count), 0);
        chk("t3_total", 32'(total), 1);
        mode = 1'b0;
        tick();

        // Saturation of candidate 3.
        pulse_reset();
        for (int k = 0; k < 255; k++) do_vote(4'b1000);
        chk("t4_sat_pre", 32'(sat_flag), 0);
        ballot_arm = 1'b1;
        tick();
        ballot_arm = 1'b0;
        vote_pulse = 4'b1000;
        tick();
        vote_pulse = '0;
        chk("t4_ack", 32'(vote_ack), 1);
        tick();
        chk("t4_sat", 32'(sat_flag), 1);
        run_busy(n);
        mode     = 1'b1;
        disp_sel = 2'd3;
        tick();
        tick();
        chk("t4_disp", 32'(disp_count), 255);
        chk("t4_total", 32'(total), 255);
        mode = 1'b0;
        tick();

        // Mixed votes and a display sweep.
        pulse_reset();
        do_vote(4'b0001);
        do_vote(4'b0001);
        do_vote(4'b0100);
        mode     = 1'b1;
        disp_sel = 2'd0;
        tick();
        tick();
        chk("t5_disp0", 32'(disp_count), 2);
        chk("t5_total", 32'(total), 3);
        disp_sel = 2'd2;
        chk("t5_latency", 32'(disp_count), 2);
        tick();
        chk("t5_disp2", 32'(disp_count), 1);
        disp_sel = 2'd1;
        tick();
        chk("t5_disp1", 32'(disp_count), 0);
        disp_sel = 2'd3;
        tick();
        chk("t5_disp3", 32'(disp_count), 0);
        ballot_arm = 1'b1;
        tick();
        ballot_arm = 1'b0;
        chk("t5_arm_ignored", 32'(armed), 0);
        chk("t5_total_hold", 32'(total), 3);
        mode = 1'b0;
        tick();
        chk("t5_total_off", 32'(total), 0);

        // Asynchronous reset during COMMIT.
        pulse_reset();
        ballot_arm = 1'b1;
        tick();
        ballot_arm = 1'b0;
        vote_pulse = 4'b0010;
        tick();
        vote_pulse = '0;
        chk("t6_ack_commit", 32'(vote_ack), 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_ack_rst", 32'(vote_ack), 0);
        chk("t6_busy_rst", 32'(busy), 0);
        tick();
        reset = 1'b1;
        tick();
        chk("t6_ack_after", 32'(vote_ack), 0);
        mode     = 1'b1;
        disp_sel = 2'd1;
        tick();
        tick();
        chk("t6_disp1", 32'(disp_count), 0);
        chk("t6_total", 32'(total), 0);
        mode = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vote_sequencer.md
Name: vote_sequencer

Overview:
- Ballot controller placed downstream of the per-candidate button debouncers. Each debouncer delivers a one-cycle valid_vote pulse.
- Admits exactly one vote per officer-armed ballot and rejects ambiguous (multi-candidate) presses.
- Commits accepted votes into a bank of saturating per-candidate tally counters, then enforces a lockout.
- In result mode it freezes voting and presents a selected candidate's tally plus the grand total for display.

Parameters:
- NUM_CAND, 4, number of candidates; equals the number of debounced vote inputs.
- CNT_W, 8, width of each per-candidate tally counter.
- LOCKOUT, 8, cycles spent in LOCK after every commit or reject before a new arm is accepted (>=1).
- ARM_TIMEOUT, 64, cycles an armed ballot waits for a vote before auto-disarming (>=2).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  0 = voting, 1 = result display; synchronous level.
- ballot_arm  in  1  officer pulse/level; arms one ballot when sampled high in IDLE.
- vote_pulse  in  NUM_CAND  one-hot-per-candidate debounced pulses (valid_vote from each debouncer).
- disp_sel  in  $clog2(NUM_CAND)  candidate index shown in result mode.
- armed  out  1  high while a ballot is open (state ARMED).
- vote_ack  out  1  one-cycle pulse: vote accepted and committed.
- vote_reject  out  1  one-cycle pulse: ballot consumed without a tally (multi-press or timeout).
- busy  out  1  high in COMMIT and LOCK.
- sat_flag  out  1  sticky: some counter was at max when a commit targeted it.
- disp_count  out  CNT_W  tally of disp_sel candidate; 0 when mode=0.
- total  out  CNT_W+$clog2(NUM_CAND)  sum of all tallies; 0 when mode=0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; all counters, sat_flag and the timers clear.
  - All outputs are 0.
  - Deassertion takes effect at the next clock edge. Reset mid-ballot or mid-lockout discards the ballot with no ack or reject.
- FSM states: IDLE, ARMED, COMMIT, LOCK, RESULT.
- IDLE:
  - mode=1 -> RESULT.
  - Otherwise ballot_arm=1 -> ARMED next cycle, armed=1, timeout counter loaded to ARM_TIMEOUT-1.
  - vote_pulse activity in IDLE is ignored.
- ARMED, evaluated in priority order:
  - mode=1 -> RESULT; the ballot is silently dropped with no pulse.
  - popcount(vote_pulse)==1 -> latch the index, go to COMMIT.
  - popcount(vote_pulse)>=2 -> vote_reject pulse in the following cycle, go to LOCK.
  - Timeout counter reaches 0 with no pulse -> vote_reject, go to LOCK.
  - ballot_arm is ignored while ARMED.
- COMMIT (exactly 1 cycle):
  - Latched counter increments by 1, visible the cycle after COMMIT. vote_ack is asserted during the COMMIT cycle.
  - If the counter equals 2^CNT_W-1 it holds its value, sat_flag is set, and vote_ack still pulses.
  - Then go to LOCK.
- LOCK:
  - busy=1; lockout counter counts LOCKOUT cycles, then IDLE.
  - vote_pulse and ballot_arm are ignored.
  - mode changes are honoured only after LOCK completes.
- RESULT:
  - Counters are frozen. disp_count = tally[disp_sel] and total = sum of tallies, both registered (1-cycle latency from disp_sel change).
  - disp_sel >= NUM_CAND yields disp_count=0.
  - mode=0 -> IDLE, and disp_count/total return to 0 next cycle.
- Timing: latency from the vote_pulse sample in ARMED to vote_ack is 1 cycle; to the updated count is 2 cycles.
- Tallies persist across RESULT; only reset clears them.
- Simultaneous arm and mode=1 in IDLE: mode wins.

Decomposition:
- Shared package vote_pkg:
  - state enum (IDLE/ARMED/COMMIT/LOCK/RESULT);
  - localparams for index width and total width;
  - popcount function.
- Sub-module vote_tally: counter bank with parameters NUM_CAND and CNT_W.
  - Inputs: inc_en, inc_idx.
  - Outputs: saturation hit, the registered mux for disp_count, and the adder-tree total.
  - Same clock/reset convention as the parent.
- vote_sequencer holds the FSM, timers and pulse generation.

Test Plan:
- Arm, then vote_pulse=4'b0010 two cycles later -> vote_ack pulses 1 cycle after the press, then LOCK for 8 cycles. RESULT with disp_sel=1 shows disp_count=1, total=1.
- Arm, then vote_pulse=4'b0110 -> vote_reject pulse, no ack, all tallies remain 0, busy high 8 cycles.
- Arm and wait 64 cycles with no press -> vote_reject at the timeout, state returns to IDLE after lockout. A vote_pulse during lockout is ignored (tallies unchanged).
- Preload candidate 3 to 255 via 255 ballots, then one more ballot for candidate 3 -> vote_ack=1, count stays 255, sat_flag=1, total=255.
- Vote candidates 0, 0, 2 in turn, enter RESULT, sweep disp_sel 0..3 -> disp_count 2, 0, 1, 0 (each 1 cycle after disp_sel), total=3. Arm pulses in RESULT have no effect.
- Drive reset low asynchronously during COMMIT of a vote for candidate 1 -> outputs go to 0 immediately, tally[1]=0 after release, no ack.
